wb_cam_capture: RTL and testbench

- Parametrised Wishbone slave camera capture unit for the LM32 SoC.
- Successor to the fixed wb_cam peripheral. Adds a configurable pixel width and buffer depth, power-of-two decimation, a one-shot arm/capture/done state machine, overflow detection and an interrupt.
- Camera timing signals arrive already synchronised to clk; each captured pixel is qualified by cam_pvalid.
- The CPU arms a capture, waits for done or irq, then drains the buffer through an auto-incrementing data port.

---
 rtl/wb_cam_capture.sv | 174 +++++++++++++++++
 tb/tb_wb_cam_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cam_capture.sv
// Wishbone camera capture: arms on START, stores one decimated frame between
// vsync rising edges into block RAM, drained through an auto-incrementing port.
module wb_cam_capture #(
  parameter int PIX_W   = 8,
  parameter int BUF_AW  = 12,
  parameter int MAX_DEC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [3:0]       wb_sel_i,
  output logic             wb_ack_o,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic             cam_pvalid,
  input  logic [PIX_W-1:0] cam_data,
  output logic             irq
);
  localparam int DEPTH = 1 << BUF_AW;

  typedef enum logic [1:0] {IDLE, ARM, CAPT} state_t;

  state_t            state_reg;
  logic [PIX_W-1:0]  mem [DEPTH];
  logic [PIX_W-1:0]  prefetch_reg;
  logic [BUF_AW:0]   count_reg;
  logic [BUF_AW-1:0] rdptr_reg;
  logic [15:0]       lines_reg;
  logic [15:0]       col_reg;
  logic [1:0]        dec_reg;
  logic [1:0]        dec_lat_reg;
  logic              ie_reg;
  logic              done_reg;
  logic              ovf_reg;
  logic              vsync_prev_reg;
  logic              href_prev_reg;
  logic              pend_reg;
  logic              ack_reg;
  logic [31:0]       dat_reg;

  logic        req, acc, wr, rd;
  logic [2:0]  sel;
  logic        start_req, abort_req;
  logic [1:0]  dec_in;
  logic        vs_rise, href_rise, href_fall;
  logic [15:0] dec_mask, col_cur;
  logic        pix_ok, full, store;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  // Request sampled -> pend_reg; the following edge performs the access and raises ack.
  assign req = wb_cyc_i & wb_stb_i & ~ack_reg;
  assign acc = pend_reg & wb_cyc_i & wb_stb_i;
  assign sel = wb_adr_i[4:2];
  assign wr  = acc & wb_we_i;
  assign rd  = acc & ~wb_we_i;

  assign start_req = wr && (sel == 3'd0) && wb_dat_i[0] && !wb_dat_i[1];
  assign abort_req = wr && (sel == 3'd0) && wb_dat_i[1];
  assign dec_in    = (32'(wb_dat_i[5:4]) > MAX_DEC) ? 2'(MAX_DEC) : wb_dat_i[5:4];

  assign vs_rise   = cam_vsync & ~vsync_prev_reg;
  assign href_rise = cam_href & ~href_prev_reg;
  assign href_fall = ~cam_href & href_prev_reg;
  assign dec_mask  = (16'd1 << dec_lat_reg) - 16'd1;
  assign col_cur   = href_rise ? 16'd0 : col_reg;

  assign pix_ok = (state_reg == CAPT) && !abort_req && cam_href && cam_pvalid &&
                  ((col_cur & dec_mask) == 16'd0) && ((lines_reg & dec_mask) == 16'd0);
  assign full   = count_reg[BUF_AW];
  assign store  = pix_ok && !full && !rst;

  assign irq = done_reg & ie_reg;

  always_comb begin
    rdata = 32'd0;
    case (sel)
      3'd0: rdata = {26'd0, dec_reg, 1'b0, ie_reg, 2'b00};
      3'd1: rdata = {28'd0, ovf_reg, done_reg, state_reg == CAPT, state_reg == ARM};
      3'd2: rdata = 32'(count_reg);
      3'd3: rdata = 32'(lines_reg);
      3'd4: rdata = 32'(rdptr_reg);
      3'd5: rdata = 32'(prefetch_reg);
      default: rdata = 32'd0;
    endcase
  end

  // Buffer: write port at COUNT, read port continuously prefetches buf[RDPTR].
  always_ff @(posedge clk) begin
    if (store) mem[count_reg[BUF_AW-1:0]] <= cam_data;
    prefetch_reg <= mem[rdptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      rdptr_reg      <= '0;
      lines_reg      <= 16'd0;
      col_reg        <= 16'd0;
      dec_reg        <= 2'd0;
      dec_lat_reg    <= 2'd0;
      ie_reg         <= 1'b0;
      done_reg       <= 1'b0;
      ovf_reg        <= 1'b0;
      vsync_prev_reg <= 1'b0;
      href_prev_reg  <= 1'b0;
      pend_reg       <= 1'b0;
      ack_reg        <= 1'b0;
      dat_reg        <= 32'd0;
    end else begin
      pend_reg       <= req & ~pend_reg;
      ack_reg        <= acc;
      dat_reg        <= rd ? rdata : 32'd0;
      vsync_prev_reg <= cam_vsync;
      href_prev_reg  <= cam_href;

      if (cam_href && cam_pvalid) col_reg <= col_cur + 16'd1;
      else if (href_rise)         col_reg <= 16'd0;

      if (wr && sel == 3'd0) begin
        ie_reg  <= wb_dat_i[2];
        dec_reg <= dec_in;
      end
      if (wr && sel == 3'd4) rdptr_reg <= wb_dat_i[BUF_AW-1:0];
      if (rd && sel == 3'd5) rdptr_reg <= rdptr_reg + BUF_AW'(1);

      case (state_reg)
        IDLE: if (start_req) begin
          state_reg   <= ARM;
          count_reg   <= '0;
          lines_reg   <= 16'd0;
          done_reg    <= 1'b0;
          ovf_reg     <= 1'b0;
          dec_lat_reg <= dec_in;
        end
        ARM: begin
          if (abort_req)    state_reg <= IDLE;
          else if (vs_rise) state_reg <= CAPT;
        end
        CAPT: begin
          if (abort_req) begin
            state_reg <= IDLE;
          end else begin
            if (store)         count_reg <= count_reg + (BUF_AW+1)'(1);
            if (pix_ok && full) ovf_reg  <= 1'b1;
            if (href_fall)     lines_reg <= lines_reg + 16'd1;
            if (vs_rise) begin
              state_reg <= IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Software clear takes priority over a same-cycle hardware set.
      if (wr && sel == 3'd1) begin
        if (wb_dat_i[2]) done_reg <= 1'b0;
        if (wb_dat_i[3]) ovf_reg  <= 1'b0;
      end
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_dat_o = dat_reg;
endmodule

// File: tb/tb_wb_cam_capture.sv
// Directed bench: a full-size unit and a 16-entry, MAX_DEC=2 unit share all
// stimulus; register-level expectations are kept in a vector table.
module tb_wb_cam_capture;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr = 32'd0;
  logic [31:0] wb_dat = 32'd0;
  logic        wb_we = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic        cam_pvalid = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, irq_a, irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cam_capture dut_a (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_a),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_sel_i(4'hF),
    .wb_ack_o(ack_a), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pvalid(cam_pvalid), .cam_data(cam_data), .irq(irq_a)
  );

  wb_cam_capture #(.PIX_W(8), .BUF_AW(4), .MAX_DEC(2)) dut_b (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat_b),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_sel_i(4'hF),
    .wb_ack_o(ack_b), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_pvalid(cam_pvalid), .cam_data(cam_data), .irq(irq_b)
  );

  typedef struct {
    int          ph;
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] ea;
    logic [31:0] eb;
    bit          chk;
  } vec_t;

  vec_t tbl[80];
  int   ntbl = 0;

  task automatic add(input int ph, input bit we, input logic [31:0] adr, wdat, ea, eb);
    tbl[ntbl] = '{ph, we, adr, wdat, ea, eb, !we};
    ntbl++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                      output logic [31:0] ra, output logic [31:0] rb);
    int n;
    n = 0;
    wb_we = we; wb_adr = adr; wb_dat = wd; wb_cyc = 1'b1; wb_stb = 1'b1;
    do begin
      tick();
      n++;
    end while (!ack_a && n < 8);
    checks++;
    if (!ack_a || n != 2 || ack_b !== ack_a) begin
      errors++;
      $display("FAIL ack_timing adr=%h got cycles=%0d ack_a=%b ack_b=%b exp cycles=2", adr, n, ack_a, ack_b);
    end
    ra = dat_a;
    rb = dat_b;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick();
    checks++;
    if (ack_a || ack_b) begin
      errors++;
      $display("FAIL ack_pulse got ack_a=%b ack_b=%b exp 0", ack_a, ack_b);
    end
    $display("xfer we=%0b adr=%h wdat=%h rd_a=%h rd_b=%h", we, adr, wd, ra, rb);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] adr, input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] ra, rb;
    xfer(1'b0, adr, 32'd0, ra, rb);
    chk({nm, "_a"}, ra, ea);
    chk({nm, "_b"}, rb, eb);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] ra, rb;
    xfer(1'b1, adr, wd, ra, rb);
  endtask

  task automatic run_phase(input int ph);
    logic [31:0] ra, rb;
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].ph == ph) begin
        xfer(tbl[i].we, tbl[i].adr, tbl[i].wdat, ra, rb);
        if (tbl[i].chk) begin
          chk($sformatf("vec%0d_a", i), ra, tbl[i].ea);
          chk($sformatf("vec%0d_b", i), rb, tbl[i].eb);
        end
      end
    end
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1;
    tick(); tick();
    cam_vsync = 1'b0;
    tick(); tick();
  endtask

  task automatic line(input int np, input int base);
    cam_href = 1'b1;
    tick();
    for (int p = 0; p < np; p++) begin
      cam_data = 8'(base + p);
      cam_pvalid = 1'b1;
      tick();
      cam_pvalid = 1'b0;
      tick();
    end
    cam_href = 1'b0;
    tick(); tick();
  endtask

  task automatic frame(input int nl, input int np);
    for (int l = 0; l < nl; l++) line(np, l * np);
  endtask

  initial begin
    int dec1_exp[8];
    logic [31:0] ra, rb;
    dec1_exp = '{0, 2, 4, 6, 16, 18, 20, 22};

    // Reset state and register access
    add(0, 0, 32'h00, 0, 0, 0);
    add(0, 0, 32'h04, 0, 0, 0);
    add(0, 0, 32'h08, 0, 0, 0);
    add(0, 0, 32'h0C, 0, 0, 0);
    add(0, 0, 32'h10, 0, 0, 0);
    add(0, 1, 32'h00, 32'h4, 0, 0);
    add(0, 0, 32'h00, 0, 32'h4, 32'h4);
    add(0, 0, 32'h18, 0, 0, 0);
    add(0, 1, 32'h1C, 32'hFFFF_FFFF, 0, 0);
    add(0, 0, 32'h1C, 0, 0, 0);
    add(0, 1, 32'h00, 32'h34, 0, 0);
    add(0, 0, 32'h00, 0, 32'h34, 32'h24);
    add(0, 1, 32'h00, 32'h0, 0, 0);
    add(0, 0, 32'h00, 0, 0, 0);
    // After full DEC=0 frame (b overflows at 16)
    add(1, 0, 32'h04, 0, 32'h4, 32'hC);
    add(1, 0, 32'h08, 0, 32, 16);
    add(1, 0, 32'h0C, 0, 4, 4);
    add(1, 0, 32'h00, 0, 32'h4, 32'h4);
    add(1, 1, 32'h10, 32'd0, 0, 0);
    // Read pointer wrap and status clear
    add(2, 1, 32'h10, 32'd15, 0, 0);
    add(2, 0, 32'h14, 0, 15, 15);
    add(2, 0, 32'h14, 0, 16, 0);
    add(2, 0, 32'h10, 0, 17, 1);
    add(2, 1, 32'h04, 32'hC, 0, 0);
    add(2, 0, 32'h04, 0, 0, 0);
    // After DEC=1 frame
    add(3, 0, 32'h04, 0, 32'h4, 32'h4);
    add(3, 0, 32'h08, 0, 8, 8);
    add(3, 0, 32'h0C, 0, 4, 4);
    add(3, 1, 32'h10, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++) add(3, 0, 32'h14, 0, dec1_exp[i], dec1_exp[i]);
    // After START issued mid-frame
    add(4, 0, 32'h04, 0, 32'h4, 32'h4);
    add(4, 0, 32'h08, 0, 8, 8);
    add(4, 0, 32'h0C, 0, 2, 2);
    add(4, 1, 32'h10, 32'd0, 0, 0);
    for (int i = 0; i < 8; i++) add(4, 0, 32'h14, 0, i, i);

    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
    chk("rst_dat_a", dat_a, 32'd0);
    chk("rst_irq", {30'd0, irq_a, irq_b}, 32'd0);
    run_phase(0);

    // Full frame, DEC=0, IE=1
    wr(32'h00, 32'h5);
    vs_pulse();
    frame(4, 8);
    vs_pulse();
    chk("f1_irq", {30'd0, irq_a, irq_b}, 32'd3);
    run_phase(1);
    for (int i = 0; i < 32; i++) begin
      xfer(1'b0, 32'h14, 32'd0, ra, rb);
      chk($sformatf("f1_data%0d_a", i), ra, 32'(i));
      chk($sformatf("f1_data%0d_b", i), rb, 32'(i % 16));
    end
    run_phase(2);
    chk("w1c_irq", {30'd0, irq_a, irq_b}, 32'd0);

    // DEC=1 frame
    wr(32'h00, 32'h15);
    vs_pulse();
    frame(4, 8);
    vs_pulse();
    run_phase(3);

    // START while a frame is already in progress
    cam_vsync = 1'b1;
    tick(); tick();
    wr(32'h00, 32'h1);
    rd_chk("mid_armed", 32'h04, 32'h1, 32'h1);
    line(4, 8'h80);
    cam_vsync = 1'b0;
    tick();
    line(4, 8'h90);
    rd_chk("mid_still_armed", 32'h04, 32'h1, 32'h1);
    vs_pulse();
    frame(2, 4);
    vs_pulse();
    chk("mid_irq", {30'd0, irq_a, irq_b}, 32'd0);
    run_phase(4);

    // ABORT during capture
    wr(32'h00, 32'h1);
    vs_pulse();
    line(4, 0);
    rd_chk("abt_busy", 32'h04, 32'h2, 32'h2);
    wr(32'h00, 32'h2);
    rd_chk("abt_status", 32'h04, 32'h0, 32'h0);
    rd_chk("abt_count", 32'h08, 32'd4, 32'd4);
    vs_pulse();
    rd_chk("abt_nodone", 32'h04, 32'h0, 32'h0);

    // Reset asserted during capture
    wr(32'h10, 32'd5);
    wr(32'h00, 32'h15);
    vs_pulse();
    line(4, 0);
    rd_chk("pre_rst_busy", 32'h04, 32'h2, 32'h2);
    rst = 1'b1;
    tick();
    chk("mid_rst_ack_irq", {28'd0, ack_a, ack_b, irq_a, irq_b}, 32'd0);
    chk("mid_rst_dat", dat_a | dat_b, 32'd0);
    rst = 1'b0;
    tick();
    rd_chk("post_rst_ctrl", 32'h00, 0, 0);
    rd_chk("post_rst_status", 32'h04, 0, 0);
    rd_chk("post_rst_count", 32'h08, 0, 0);
    rd_chk("post_rst_lines", 32'h0C, 0, 0);
    rd_chk("post_rst_rdptr", 32'h10, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
